// File: rtl/i2c_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_arbiter
//
// Shares one I2C engine and its command-ROM address counter between N
// requesters. Pending requests are arbitrated round-robin. The winner's ROM
// start address is loaded into the address counter, the engine is kicked,
// and the engine busy flag is tracked until the transaction ends. While a
// transaction runs, read-byte strobes go only to the granted requester.
//
// Optional feature macro: I2C_ARB_TIMEOUT_EN
//   When defined, a transaction that stays in WAIT_BUSY/RUN for TIMEOUT
//   cycles is aborted: ERR pulses in place of DONE. When undefined, ERR is
//   tied to 0 and the FSM waits for the engine indefinitely.
//
// Ports
//   CLK         system clock (rising edge)
//   RESET       synchronous, active-high reset
//   REQ[N]      level request per requester
//   ADDR[N*AW]  ROM start address per requester, slice i = ADDR[i*AW +: AW]
//   GNT[N]      one-hot grant, held from LOAD through FIN
//   DONE[N]     one-cycle completion pulse to the granted requester
//   ERR[N]      one-cycle timeout-abort pulse to the granted requester
//   DATA_EN[N]  I2C_WR_ADV routed to the granted requester
//   SET_ADDR    load strobe for the command-ROM address counter
//   SET_VAL[AW] address loaded with SET_ADDR
//   I2C_START   one-cycle start pulse to the engine
//   I2C_BUSY    engine busy flag
//   I2C_WR_ADV  engine read-byte strobe
// ---------------------------------------------------------------------------
module i2c_arbiter #(
  parameter int N       = 4,
  parameter int AW      = 6,
  parameter int TW      = 20,
  parameter int TIMEOUT = 500000
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N-1:0]    REQ,
  input  logic [N*AW-1:0] ADDR,
  output logic [N-1:0]    GNT,
  output logic [N-1:0]    DONE,
  output logic [N-1:0]    ERR,
  output logic [N-1:0]    DATA_EN,
  output logic            SET_ADDR,
  output logic [AW-1:0]   SET_VAL,
  output logic            I2C_START,
  input  logic            I2C_BUSY,
  input  logic            I2C_WR_ADV
);

  localparam int PW = $clog2(N);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_KICK = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  // Reject configurations the counter or pointer cannot represent.
  if (N < 2 || N > 8 || AW < 1 || TIMEOUT < 2 || TIMEOUT > (1 << TW)) begin : g_cfg_err
    $error("i2c_arbiter: unsupported parameter combination");
  end

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gidx_q, gidx_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          abort_q, abort_d;

  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] scan_idx;
  logic          tmo_hit;
  logic          active;

  assign active = (state_q == S_WAIT) || (state_q == S_RUN);

  // Round-robin: first set REQ bit scanning upward from ptr, wrapping at N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = PW'((int'(ptr_q) + k) % N);
      if (!win_found && REQ[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_q, tmo_d;

  // Counts cycles spent waiting on the engine; cleared when a new address
  // is loaded so each transaction gets the full budget.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_LOAD) begin
      tmo_d = '0;
    end else if (active) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  assign tmo_hit = active && (tmo_q == TMO_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign ERR = (state_q == S_FIN && abort_q) ? gnt_q : '0;
`else
  assign tmo_hit = 1'b0;
  assign ERR     = '0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    abort_d = abort_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          gidx_d         = win_idx;
          addr_d         = ADDR[int'(win_idx)*AW +: AW];
          abort_d        = 1'b0;
          state_d        = S_LOAD;
        end
      end
      S_LOAD: state_d = S_KICK;
      S_KICK: state_d = S_WAIT;
      S_WAIT: begin
        if (tmo_hit) begin
          abort_d = 1'b1;
          state_d = S_FIN;
        end else if (I2C_BUSY) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (tmo_hit) begin
          abort_d = 1'b1;
          state_d = S_FIN;
        end else if (!I2C_BUSY) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        // The just-served requester drops to lowest priority.
        ptr_d   = (int'(gidx_q) == N - 1) ? '0 : gidx_q + 1'b1;
        gnt_d   = '0;
        addr_d  = '0;
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      abort_q <= abort_d;
    end
  end

  assign GNT       = gnt_q;
  assign SET_ADDR  = (state_q == S_LOAD);
  assign SET_VAL   = (state_q == S_LOAD) ? addr_q : '0;
  assign I2C_START = (state_q == S_KICK);
  assign DONE      = (state_q == S_FIN && !abort_q) ? gnt_q : '0;
  // Only strobe path that is not registered: the engine's byte strobe is
  // forwarded in the same cycle, and only while the engine is ours.
  assign DATA_EN   = active ? (gnt_q & {N{I2C_WR_ADV}}) : '0;

endmodule
